clock_gate_ctrl: RTL and testbench
==================================

Name: clock_gate_ctrl

Overview:
- Idle-detect controller that produces the enable for the downstream latch-based clock gating cell.
- Watches block activity and counts consecutive idle cycles.
- Runs a quiesce handshake with the gated block before stopping its clock.
- Re-enables the clock on demand, with a settle period before declaring the block ready.

Parameters:
IDLE_W, 8, width of idle counter and idle_threshold
WAKE_CYCLES, 2, cycles after clk_enable rises before ready asserts (must be >= 1)
STAT_W, 32, width of statistics counters

Ports:
clk  input  1  free-running clock (ungated side)
rst_n  input  1  asynchronous active-low reset
idle_threshold  input  IDLE_W  consecutive idle cycles before gating; 0 disables gating
activity  input  1  work pending for the gated block (request or busy)
force_on  input  1  override: keep clock running, abort or wake
quiesce_ack  input  1  gated block confirms it is safe to stop
quiesce_req  output  1  request to gated block to reach a safe idle point
clk_enable  output  1  enable to the clock gating cell
ready  output  1  gated clock running and settled; upstream may issue work
state  output  2  FSM state: RUN=0, QUIESCE=1, GATED=2, WAKE=3
gated_cycles  output  STAT_W  cycles spent in GATED
gate_events  output  STAT_W  QUIESCE->GATED transitions

Behaviour:
- All outputs are registered; there is no combinational path from inputs to clk_enable.
- Reset (async assert, sync release):
  - state=RUN, clk_enable=1, ready=1, quiesce_req=0.
  - idle_cnt=0, wake_cnt=0, stats=0.
  - Clock is on in reset so the gated block sees its own reset.
- RUN:
  - clk_enable=1, ready=1, quiesce_req=0.
  - idle_cnt increments (saturating at all-ones) on each edge sampling activity=0 and force_on=0.
  - idle_cnt clears on any edge sampling activity=1 or force_on=1.
  - Go to QUIESCE when idle_threshold!=0, activity=0, force_on=0 and idle_cnt+1 >= idle_threshold.
  - With threshold N and activity low from edge 1, QUIESCE is entered at edge N.
  - Comparison uses the live idle_threshold. Lowering it below idle_cnt triggers QUIESCE at the next idle edge.
- QUIESCE:
  - clk_enable=1, ready=0, quiesce_req=1.
  - activity=1 or force_on=1 -> RUN (abort). Abort has priority over a same-cycle quiesce_ack.
  - Else quiesce_ack=1 -> GATED; clk_enable=0 from that edge.
  - No timeout; waits indefinitely for ack.
- GATED:
  - clk_enable=0, ready=0, quiesce_req held 1.
  - activity=1 or force_on=1 -> WAKE; clk_enable=1 and quiesce_req=0 from that edge; wake_cnt loaded with WAKE_CYCLES.
- WAKE:
  - clk_enable=1, ready=0, quiesce_req=0.
  - wake_cnt decrements each edge; at 1 -> RUN, so ready=1 exactly WAKE_CYCLES edges after the GATED->WAKE edge.
  - activity and force_on are ignored in WAKE.
- quiesce_ack is ignored outside QUIESCE.
- idle_cnt clears on every entry to RUN.
- Reset asserted in any state returns immediately to the reset values (clock re-enabled asynchronously).

Optional Feature:
Macro GATE_STATS_EN.
- Defined:
  - gated_cycles increments on every edge where state==GATED (before the edge), saturating at all-ones.
  - gate_events increments on each QUIESCE->GATED edge, saturating.
- Not defined: counters are not built; gated_cycles and gate_events are tied to 0.

Test Plan:
- threshold=4, activity=0 after reset, quiesce_ack driven 1 one cycle after quiesce_req -> quiesce_req=1 after edge 4, state=GATED and clk_enable=0 after edge 6.
- In QUIESCE, activity=1 and quiesce_ack=1 in the same cycle -> state=RUN, clk_enable stays 1, quiesce_req=0, gate_events unchanged.
- In GATED, 1-cycle activity pulse, WAKE_CYCLES=2 -> clk_enable=1 and state=WAKE next edge, ready=1 two edges later, state=RUN.
- threshold=0 and 100 idle cycles -> state stays RUN, clk_enable=1. Then threshold=3 with force_on=1 -> still RUN. Release force_on -> QUIESCE after 3 idle edges.
- rst_n pulled low while GATED -> clk_enable=1, ready=1, state=RUN, quiesce_req=0 immediately, without waiting for a clk edge.
- Three gate/wake episodes of 10 GATED cycles each:
  - With GATE_STATS_EN -> gate_events=3, gated_cycles=30.
  - Without GATE_STATS_EN -> both read 0.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: idle-detect controller driving the enable of a latch-based
// clock gating cell. It counts consecutive idle cycles, runs a quiesce
// handshake with the gated block, stops its clock, and re-enables it on
// demand with a settle period before declaring the block ready.
//
// Optional feature macro: GATE_STATS_EN
//   defined     -> gated_cycles / gate_events saturating statistics counters
//   not defined -> statistics outputs tied to zero
module clock_gate_ctrl #(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDLE_W-1:0] idle_threshold,
  input  logic              activity,
  input  logic              force_on,
  input  logic              quiesce_ack,
  output logic              quiesce_req,
  output logic              clk_enable,
  output logic              ready,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] gated_cycles,
  output logic [STAT_W-1:0] gate_events
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_QUIESCE = 2'd1;
  localparam logic [1:0] ST_GATED   = 2'd2;
  localparam logic [1:0] ST_WAKE    = 2'd3;

  localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES);
  localparam logic [WAKE_W-1:0] WAKE_ONE  = {{(WAKE_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r, state_nxt_s;
  logic [IDLE_W-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic [WAKE_W-1:0] wake_cnt_r, wake_cnt_nxt_s;
  logic              clk_enable_r, ready_r, quiesce_req_r;
  logic              wake_s;
  logic [IDLE_W:0]   idle_inc_s;

  // Any pending work or an override counts as a reason to keep/restore the clock.
  assign wake_s     = activity | force_on;
  // One extra bit so the threshold compare cannot wrap at saturation.
  assign idle_inc_s = {1'b0, idle_cnt_r} + {{IDLE_W{1'b0}}, 1'b1};

  // Next-state, idle counter and wake counter decisions.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    wake_cnt_nxt_s = wake_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (wake_s) begin
          idle_cnt_nxt_s = {IDLE_W{1'b0}};
        end else if (idle_cnt_r != {IDLE_W{1'b1}}) begin
          idle_cnt_nxt_s = idle_inc_s[IDLE_W-1:0];
        end else begin
          idle_cnt_nxt_s = idle_cnt_r;
        end
        // Live threshold compare: lowering it below the count gates at the next idle edge.
        if (!wake_s && (idle_threshold != {IDLE_W{1'b0}}) &&
            (idle_inc_s >= {1'b0, idle_threshold})) begin
          state_nxt_s = ST_QUIESCE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_QUIESCE: begin
        // Abort wins over a same-cycle acknowledge.
        if (wake_s) begin
          state_nxt_s    = ST_RUN;
          idle_cnt_nxt_s = {IDLE_W{1'b0}};
        end else if (quiesce_ack) begin
          state_nxt_s = ST_GATED;
        end else begin
          state_nxt_s = ST_QUIESCE;
        end
      end
      ST_GATED: begin
        if (wake_s) begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = WAKE_LOAD;
        end else begin
          state_nxt_s = ST_GATED;
        end
      end
      ST_WAKE: begin
        // Requests are ignored here; the settle period always runs to completion.
        if (wake_cnt_r <= WAKE_ONE) begin
          state_nxt_s    = ST_RUN;
          idle_cnt_nxt_s = {IDLE_W{1'b0}};
          wake_cnt_nxt_s = {WAKE_W{1'b0}};
        end else begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = wake_cnt_r - WAKE_ONE;
        end
      end
      default: begin
        state_nxt_s    = ST_RUN;
        idle_cnt_nxt_s = {IDLE_W{1'b0}};
        wake_cnt_nxt_s = {WAKE_W{1'b0}};
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they are registered and change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      idle_cnt_r    <= {IDLE_W{1'b0}};
      wake_cnt_r    <= {WAKE_W{1'b0}};
      clk_enable_r  <= 1'b1;
      ready_r       <= 1'b1;
      quiesce_req_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idle_cnt_r    <= idle_cnt_nxt_s;
      wake_cnt_r    <= wake_cnt_nxt_s;
      clk_enable_r  <= (state_nxt_s != ST_GATED);
      ready_r       <= (state_nxt_s == ST_RUN);
      quiesce_req_r <= (state_nxt_s == ST_QUIESCE) || (state_nxt_s == ST_GATED);
    end
  end

  assign state       = state_r;
  assign clk_enable  = clk_enable_r;
  assign ready       = ready_r;
  assign quiesce_req = quiesce_req_r;

`ifdef GATE_STATS_EN
  logic [STAT_W-1:0] gated_cycles_r, gate_events_r;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Saturating counts of gated cycles and of completed gate handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cycles_r <= {STAT_W{1'b0}};
      gate_events_r  <= {STAT_W{1'b0}};
    end else begin
      if ((state_r == ST_GATED) && (gated_cycles_r != {STAT_W{1'b1}})) begin
        gated_cycles_r <= gated_cycles_r + STAT_ONE;
      end
      if ((state_r == ST_QUIESCE) && (state_nxt_s == ST_GATED) &&
          (gate_events_r != {STAT_W{1'b1}})) begin
        gate_events_r <= gate_events_r + STAT_ONE;
      end
    end
  end

  assign gated_cycles = gated_cycles_r;
  assign gate_events  = gate_events_r;
`else
  assign gated_cycles = {STAT_W{1'b0}};
  assign gate_events  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: a vector table for the basic
// gate/wake/abort flow, hand-written corner sequences, and a randomized run
// compared against a behavioural model kept here.
module tb_clock_gate_ctrl;

  localparam int IDLE_W = 8;
  localparam int WAKE_CYCLES = 2;
  localparam int STAT_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IDLE_W-1:0] idle_threshold = 8'd0;
  logic              activity = 1'b0;
  logic              force_on = 1'b0;
  logic              quiesce_ack = 1'b0;
  logic              quiesce_req, clk_enable, ready;
  logic [1:0]        state;
  logic [STAT_W-1:0] gated_cycles, gate_events;

  int total = 0;
  int bad = 0;

  clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_CYCLES(WAKE_CYCLES), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .idle_threshold(idle_threshold), .activity(activity),
    .force_on(force_on), .quiesce_ack(quiesce_ack), .quiesce_req(quiesce_req),
    .clk_enable(clk_enable), .ready(ready), .state(state),
    .gated_cycles(gated_cycles), .gate_events(gate_events)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (mode name + plain integer counts)
  typedef enum int {M_RUN = 0, M_QUIESCE = 1, M_GATED = 2, M_WAKE = 3} mode_t;
  mode_t   m_mode;
  int      m_idle, m_wake;
  longint  m_gated, m_events;

  task automatic model_reset();
    m_mode = M_RUN; m_idle = 0; m_wake = 0; m_gated = 0; m_events = 0;
  endtask

  task automatic model_edge(input bit a, input bit f, input bit ack, input int thr);
    bit busy;
    busy = a || f;
    case (m_mode)
      M_RUN: begin
        if (!busy && thr != 0 && m_idle + 1 >= thr) m_mode = M_QUIESCE;
        m_idle = busy ? 0 : ((m_idle + 1 > 255) ? 255 : m_idle + 1);
      end
      M_QUIESCE: begin
        if (busy) begin m_mode = M_RUN; m_idle = 0; end
        else if (ack) begin m_mode = M_GATED; m_events++; end
      end
      M_GATED: begin
        m_gated++;
        if (busy) begin m_mode = M_WAKE; m_wake = WAKE_CYCLES; end
      end
      default: begin
        if (m_wake == 1) begin m_mode = M_RUN; m_idle = 0; end
        else m_wake--;
      end
    endcase
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's view of the spec.
  task automatic check_model(input string tag);
    longint exp_gc, exp_ge;
`ifdef GATE_STATS_EN
    exp_gc = m_gated; exp_ge = m_events;
`else
    exp_gc = 0; exp_ge = 0;
`endif
    check({tag, ".state"}, state, int'(m_mode));
    check({tag, ".clk_enable"}, clk_enable, (m_mode != M_GATED) ? 1 : 0);
    check({tag, ".ready"}, ready, (m_mode == M_RUN) ? 1 : 0);
    check({tag, ".quiesce_req"}, quiesce_req, (m_mode == M_QUIESCE || m_mode == M_GATED) ? 1 : 0);
    check({tag, ".gated_cycles"}, gated_cycles, exp_gc);
    check({tag, ".gate_events"}, gate_events, exp_ge);
  endtask

  // One clock edge with the currently driven inputs; sample 1 ns after.
  task automatic step();
    @(posedge clk);
    model_edge(activity, force_on, quiesce_ack, int'(idle_threshold));
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; activity = 1'b0; force_on = 1'b0; quiesce_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- vector table
  typedef struct {
    bit a; bit f; bit ack; logic [7:0] thr;
    logic [1:0] st; bit ce; bit rdy; bit qr;
  } vec_t;
  vec_t vecs[14];

  function automatic vec_t mk(bit a, bit f, bit ack, logic [7:0] thr,
                              logic [1:0] st, bit ce, bit rdy, bit qr);
    vec_t v;
    v.a = a; v.f = f; v.ack = ack; v.thr = thr; v.st = st; v.ce = ce; v.rdy = rdy; v.qr = qr;
    return v;
  endfunction

  initial begin
    // threshold 4: QUIESCE at edge 4, ack at edge 6 -> GATED, wake, abort
    vecs[0]  = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[1]  = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[2]  = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[3]  = mk(0, 0, 0, 8'd4, 2'd1, 1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 8'd4, 2'd1, 1, 0, 1);
    vecs[5]  = mk(0, 0, 1, 8'd4, 2'd2, 0, 0, 1);
    vecs[6]  = mk(1, 0, 0, 8'd4, 2'd3, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 8'd4, 2'd3, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 8'd4, 2'd0, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 8'd4, 2'd1, 1, 0, 1);
    vecs[13] = mk(1, 0, 1, 8'd4, 2'd0, 1, 1, 0);  // abort beats ack
  end

  initial begin
    longint ge_before;
    do_reset();
    check("reset.state", state, 0);
    check("reset.clk_enable", clk_enable, 1);
    check("reset.ready", ready, 1);
    check("reset.quiesce_req", quiesce_req, 0);
    check("reset.gated_cycles", gated_cycles, 0);
    check("reset.gate_events", gate_events, 0);

    // Table-driven flow
    ge_before = 0;
    for (int i = 0; i < 14; i++) begin
      activity = vecs[i].a; force_on = vecs[i].f; quiesce_ack = vecs[i].ack;
      idle_threshold = vecs[i].thr;
      if (i == 13) ge_before = gate_events;
      step();
      check($sformatf("vec%0d.state", i), state, vecs[i].st);
      check($sformatf("vec%0d.clk_enable", i), clk_enable, vecs[i].ce);
      check($sformatf("vec%0d.ready", i), ready, vecs[i].rdy);
      check($sformatf("vec%0d.quiesce_req", i), quiesce_req, vecs[i].qr);
    end
    check("abort.gate_events_unchanged", gate_events, ge_before);
`ifdef GATE_STATS_EN
    check("table.gate_events", gate_events, 1);
`else
    check("table.gate_events", gate_events, 0);
`endif
    activity = 1'b0; quiesce_ack = 1'b0;

    // Threshold 0 disables gating
    do_reset();
    idle_threshold = 8'd0;
    for (int i = 0; i < 100; i++) begin
      step();
      check_model("thr0");
    end
    check("thr0.state", state, 0);
    check("thr0.clk_enable", clk_enable, 1);
    // force_on holds RUN, then three idle edges after release
    idle_threshold = 8'd3; force_on = 1'b1;
    repeat (5) begin step(); check("force.state", state, 0); end
    force_on = 1'b0;
    step(); check("rel1.state", state, 0);
    step(); check("rel2.state", state, 0);
    step(); check("rel3.state", state, 1);
    check_model("rel");

    // Async reset while GATED
    quiesce_ack = 1'b1; step(); quiesce_ack = 1'b0;
    check("pre_rst.state", state, 2);
    check("pre_rst.clk_enable", clk_enable, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.clk_enable", clk_enable, 1);
    check("async_rst.ready", ready, 1);
    check("async_rst.state", state, 0);
    check("async_rst.quiesce_req", quiesce_req, 0);
    do_reset();

    // Three gate/wake episodes of ten gated cycles each
    idle_threshold = 8'd1;
    for (int e = 0; e < 3; e++) begin
      step();                                   // RUN -> QUIESCE
      quiesce_ack = 1'b1; step(); quiesce_ack = 1'b0;  // -> GATED
      repeat (9) step();
      activity = 1'b1; step(); activity = 1'b0;        // 10th gated edge -> WAKE
      step(); step();                                   // settle -> RUN
      check_model($sformatf("ep%0d", e));
    end
`ifdef GATE_STATS_EN
    check("episodes.gate_events", gate_events, 3);
    check("episodes.gated_cycles", gated_cycles, 30);
`else
    check("episodes.gate_events", gate_events, 0);
    check("episodes.gated_cycles", gated_cycles, 0);
`endif

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      activity    = ($urandom_range(0, 5) == 0);
      force_on    = ($urandom_range(0, 15) == 0);
      quiesce_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) idle_threshold = 8'($urandom_range(0, 6));
      step();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
